// File: rtl/occ_table_server.sv
// rtl/occ_table_server.sv - Occ table builder and registered rom_Occ read responder
// Optional: OCC_ZERO_ROW_EN reserves row 8'hFF as an always-zero "empty prefix" row.
module occ_table_server #(
  parameter int DEPTH = 256,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_start,
  input  logic               sym_valid,
  output logic               sym_ready,
  input  logic [1:0]         sym,
  input  logic               sym_is_end,
  input  logic               sym_last,
  input  logic               ce_rom_Occ,
  input  logic [7:0]         addr_rom_Occ,
  output logic [4*CNT_W-1:0] data,
  output logic               table_ready,
  output logic [8:0]         table_len,
  output logic               busy,
  output logic               err_sat,
  output logic               err_len
);

`ifdef OCC_ZERO_ROW_EN
  localparam int LAST_ROW = DEPTH - 2;
`else
  localparam int LAST_ROW = DEPTH - 1;
`endif
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  typedef enum logic [1:0] {IDLE, BUILD, READY} state_t;

  state_t             state, state_nxt;
  logic [4*CNT_W-1:0] cnt, cnt_nxt;
  logic [7:0]         wptr;
  logic               accept, at_last_row, sat_hit, rd_hit;
  logic [4*CNT_W-1:0] mem [DEPTH];

  assign sym_ready   = (state == BUILD) && !load_start;
  assign accept      = sym_valid && sym_ready;
  assign at_last_row = (wptr == 8'(LAST_ROW));
  assign busy        = (state == BUILD);
  assign table_ready = (state == READY);

`ifdef OCC_ZERO_ROW_EN
  assign rd_hit = (state == READY) && ({1'b0, addr_rom_Occ} < table_len) && (addr_rom_Occ != 8'hFF);
`else
  assign rd_hit = (state == READY) && ({1'b0, addr_rom_Occ} < table_len);
`endif

  // A saturated lane holds at its maximum and only flags the event.
  always_comb begin
    cnt_nxt = cnt;
    sat_hit = 1'b0;
    if (!sym_is_end) begin
      if (cnt[sym*CNT_W +: CNT_W] == CNT_MAX) sat_hit = 1'b1;
      else cnt_nxt[sym*CNT_W +: CNT_W] = cnt[sym*CNT_W +: CNT_W] + CNT_ONE;
    end
  end

  always_comb begin
    state_nxt = state;
    if (load_start) begin
      state_nxt = BUILD;
    end else if (state == BUILD && accept && (sym_last || at_last_row)) begin
      state_nxt = READY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      wptr      <= '0;
      table_len <= '0;
      err_sat   <= 1'b0;
      err_len   <= 1'b0;
      data      <= '0;
    end else begin
      state <= state_nxt;
      // Read uses the pre-edge state, so a read alongside load_start still sees the old table.
      if (ce_rom_Occ) data <= rd_hit ? mem[addr_rom_Occ] : '0;
      if (load_start) begin
        cnt       <= '0;
        wptr      <= '0;
        table_len <= '0;
        err_sat   <= 1'b0;
        err_len   <= 1'b0;
      end else if (accept) begin
        cnt  <= cnt_nxt;
        wptr <= wptr + 8'd1;
        if (sat_hit) err_sat <= 1'b1;
        if (sym_last) begin
          table_len <= {1'b0, wptr} + 9'd1;
        end else if (at_last_row) begin
          table_len <= 9'(LAST_ROW + 1);
          err_len   <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wptr] <= cnt_nxt;
  end

endmodule

// File: tb/tb_occ_table_server.sv
// tb/tb_occ_table_server.sv - randomized check of occ_table_server against a cumulative-count model
module tb_occ_table_server;

  logic        clk = 1'b0;
  logic        rst, load_start, sym_valid, sym_is_end, sym_last, ce_rom_Occ;
  logic [1:0]  sym;
  logic [7:0]  addr_rom_Occ;
  logic [31:0] data;
  logic [8:0]  table_len;
  logic        sym_ready, table_ready, busy, err_sat, err_len;

`ifdef OCC_ZERO_ROW_EN
  localparam int MAX_ROWS = 255;
  localparam bit ZERO_ROW = 1'b1;
`else
  localparam int MAX_ROWS = 256;
  localparam bit ZERO_ROW = 1'b0;
`endif

  occ_table_server dut (
    .clk(clk), .rst(rst), .load_start(load_start),
    .sym_valid(sym_valid), .sym_ready(sym_ready), .sym(sym),
    .sym_is_end(sym_is_end), .sym_last(sym_last),
    .ce_rom_Occ(ce_rom_Occ), .addr_rom_Occ(addr_rom_Occ), .data(data),
    .table_ready(table_ready), .table_len(table_len), .busy(busy),
    .err_sat(err_sat), .err_len(err_len)
  );

  always #5 clk = ~clk;

  logic [31:0] m_rows [256];
  int          m_cnt [4];
  int          m_len, m_wptr;
  bit          m_ready, m_busy, m_sat, m_errlen;
  int          passed = 0;
  int          total  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] m_read(input int a);
    if (m_ready && a < m_len && !(ZERO_ROW && a == 255)) return m_rows[a];
    return 32'h0;
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    m_wptr = 0; m_len = 0; m_ready = 0; m_busy = 1; m_sat = 0; m_errlen = 0;
  endfunction

  function automatic void m_accept(input int s, input bit e, input bit l);
    if (!e) begin
      if (m_cnt[s] < 255) m_cnt[s]++;
      else m_sat = 1;
    end
    m_rows[m_wptr] = m_cnt[0] + (m_cnt[1] << 8) + (m_cnt[2] << 16) + (m_cnt[3] << 24);
    m_wptr++;
    if (l || m_wptr == MAX_ROWS) begin
      m_ready = 1; m_busy = 0; m_len = m_wptr;
      if (!l) m_errlen = 1;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag);
    check({tag, ".ready"},   table_ready, m_ready);
    check({tag, ".busy"},    busy,        m_busy);
    check({tag, ".len"},     table_len,   m_len);
    check({tag, ".err_sat"}, err_sat,     m_sat);
    check({tag, ".err_len"}, err_len,     m_errlen);
  endtask

  task automatic do_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    m_clear();
  endtask

  task automatic send(input int s, input bit e, input bit l);
    if ($urandom_range(0, 3) == 0) tick();
    sym_valid = 1'b1; sym = 2'(s); sym_is_end = e; sym_last = l;
    #1;
    check("sym_ready", sym_ready, 1'b1);
    tick();
    sym_valid = 1'b0; sym_last = 1'b0; sym_is_end = 1'b0;
    m_accept(s, e, l);
  endtask

  task automatic rd(input int a, input logic [31:0] exp);
    ce_rom_Occ = 1'b1; addr_rom_Occ = 8'(a);
    tick();
    check($sformatf("rd[%0d]", a), data, exp);
    ce_rom_Occ = 1'b0; addr_rom_Occ = 8'($urandom);
    tick();
    check($sformatf("hold[%0d]", a), data, exp);
  endtask

  initial begin
    logic [31:0] golden [5];
    golden[0] = 32'h00000100; golden[1] = 32'h00000100; golden[2] = 32'h00000101;
    golden[3] = 32'h00000102; golden[4] = 32'h00010102;

    rst = 1'b1; load_start = 1'b0; sym_valid = 1'b0; sym = 2'd0; sym_is_end = 1'b0;
    sym_last = 1'b0; ce_rom_Occ = 1'b0; addr_rom_Occ = 8'd0;
    m_clear(); m_busy = 0;
    tick(); tick();
    check("reset.data", data, 32'h0);
    check_status("reset");
    rst = 1'b0;
    tick();

    // Reset in the middle of a build
    do_load();
    check_status("build_start");
    for (int i = 0; i < 3; i++) send($urandom_range(0, 3), 1'b0, 1'b0);
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    m_clear(); m_busy = 0;
    tick();
    check_status("midreset");
    for (int a = 0; a < 3; a++) rd(a, 32'h0);

    // Basic build C,$,A,A,G
    do_load();
    send(1, 1'b0, 1'b0); send(0, 1'b1, 1'b0); send(0, 1'b0, 1'b0);
    send(0, 1'b0, 1'b0); send(2, 1'b0, 1'b1);
    check_status("basic");
    check("basic.ready_now", table_ready, 1'b1);
    check("basic.len5", table_len, 9'd5);
    for (int a = 0; a < 5; a++) rd(a, golden[a]);
    rd(3, 32'h00000102);
    rd(7, 32'h0);
    rd(255, 32'h0);

    // Read on the same edge as load_start sees the old table
    ce_rom_Occ = 1'b1; addr_rom_Occ = 8'd2; load_start = 1'b1;
    tick();
    check("preload_rd", data, golden[2]);
    ce_rom_Occ = 1'b0; load_start = 1'b0;
    m_clear();
    check_status("preload");

    // Saturation of lane A
    for (int i = 0; i < 256; i++) begin
      if (m_ready) break;
      send(0, 1'b0, i == 255);
    end
    check_status("sat");
    rd(254, 32'h000000FF);
    rd(255, m_read(255));
    rd(0, 32'h00000001);

    // Restart collision and length overflow
    do_load();
    for (int i = 0; i < 3; i++) send($urandom_range(0, 3), 1'b0, 1'b0);
    sym_valid = 1'b1; sym = 2'd3; load_start = 1'b1;
    #1;
    check("collide.sym_ready", sym_ready, 1'b0);
    tick();
    sym_valid = 1'b0; load_start = 1'b0;
    m_clear();
    for (int i = 0; i < 300; i++) begin
      if (m_ready) break;
      send($urandom_range(0, 3), $urandom_range(0, 7) == 0, 1'b0);
    end
    check_status("overflow");
    rd(0, m_read(0));
    rd(MAX_ROWS - 1, m_read(MAX_ROWS - 1));
    rd(255, m_read(255));

    // Random builds with random reads
    for (int b = 0; b < 6; b++) begin
      int n;
      n = $urandom_range(1, 60);
      do_load();
      for (int i = 0; i < n; i++)
        send($urandom_range(0, 3), $urandom_range(0, 7) == 0, i == n - 1);
      check_status($sformatf("rand%0d", b));
      for (int k = 0; k < 8; k++) begin
        int a;
        a = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 63);
        rd(a, m_read(a));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
